rf_wb_queue: RTL and testbench
==============================

// Module: rf_wb_queue
// PURPOSE
//  Write-side front end of the 32x32 register file. Completed results from
//  ALU/load paths enter a small in-order queue and drain one per cycle onto
//  the RF write port (RegWrite/wr_addr/wr_data). Provides per-read-port
//  pending/forward lookup so decode sees values not yet committed to the RF.
// PARAMETERS
//  DEPTH  4   queue entries, power of two, >=2
//  AW     5   register address width
//  DW     32  data width
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  enq_valid  in   1      result available
//  enq_ready  out  1      queue can accept this cycle
//  enq_addr   in   AW     destination register
//  enq_data   in   DW     result value
//  wb_stall   in   1      RF write port unavailable; hold head
//  RegWrite   out  1      RF write enable (registered)
//  wr_addr    out  AW     RF write address (registered)
//  wr_data    out  DW     RF write data (registered)
//  rd_addr1   in   AW     lookup address, read port 1
//  rd_addr2   in   AW     lookup address, read port 2
//  fwd_hit1   out  1      newer value for rd_addr1 pending
//  fwd_data1  out  DW     that value
//  fwd_hit2   out  1      same, read port 2
//  fwd_data2  out  DW     same, read port 2
//  empty      out  1      queue and output stage both idle
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptr=0, RegWrite=0, wr_addr=0, wr_data=0,
//    fwd_hit*=0, empty=1, enq_ready=0 while rst high. Pending entries
//    dropped, no RF write issued. Applies mid-operation too.
//  - enq_ready = !rst && count<DEPTH. No same-cycle pass-through when full.
//  - Accept: enq_valid&&enq_ready at posedge -> entry at wr_ptr, wr_ptr++.
//  - enq_addr==0: accepted (handshake completes), not stored, never written.
//  - Dequeue: count>0 && !wb_stall at posedge -> head to output stage:
//    RegWrite<=1, wr_addr/wr_data<=head; rd_ptr++. Otherwise RegWrite<=0,
//    wr_addr/wr_data hold previous value.
//  - Simultaneous accept+dequeue: count unchanged; both pointers advance.
//  - Pointers wrap modulo DEPTH; count 0..DEPTH, full/empty from count.
//  - Latency: accept at edge N into empty queue -> RegWrite high after N+1
//    -> RF updated at N+2. Strict FIFO order; one write per cycle max.
//  - wb_stall affects only dequeue; accepts continue until full.
//  - Forward lookup (combinational from registered state only):
//    priority newest queue entry matching rd_addrX, then output stage if
//    RegWrite && wr_addr==rd_addrX, else hit=0. rd_addrX==0 -> hit=0.
//    fwd_dataX=0 when no hit. Same-cycle enq_data is NOT forwarded.
//  - empty = (count==0) && !RegWrite.
// STRUCTURE
//  - Package rf_wb_pkg: AW/DW defaults, entry struct {addr,data}, log2 DEPTH.
//  - Sub-module wb_fifo: circular buffer, ptrs, count, exposes entry array
//    for the lookup. Top holds output stage and two lookup instances
//    (function fwd_lookup, newest-first scan from wr_ptr-1).
// TESTING
//  - Reset: rst 2 cycles -> RegWrite=0, wr_addr=0, enq_ready=0 then 1, empty=1.
//  - Enq (3,0xAA) edge N -> RegWrite=1, wr_addr=3, wr_data=0xAA after N+1 only.
//  - wb_stall=1, enq r1..r4 -> enq_ready=0 after 4th; 5th held; release ->
//    writes r1,r2,r3,r4 in 4 consecutive cycles, then 5th.
//  - Enq (7,0x11) then (7,0x22), stall: rd_addr1=7 -> fwd_hit1=1, 0x22;
//    rd_addr2=0 -> fwd_hit2=0.
//  - Full + enq_valid + dequeue same cycle -> not accepted; count DEPTH-1.
//  - rst with 3 pending -> no RegWrite ever asserted for them; enq (0,x) -> no write.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file write-back queue.
//   AW_DEF / DW_DEF / DEPTH_DEF : default address width, data width, queue depth
//   wb_entry_t                  : one pending write {addr, data}
//   log2c()                     : ceiling log2, used to size pointers
package rf_wb_pkg;

  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 4;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer holding pending register writes in arrival order.
//   clk, rst            : clock, synchronous active-high reset
//   push/push_addr/data : store one entry at the write pointer
//   pop                 : retire the head entry
//   head_addr/head_data : oldest entry
//   wr_ptr, count       : write pointer and occupancy (0..DEPTH)
//   ent_addr/ent_data   : whole storage array, for forwarding lookups
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF,
  localparam int unsigned PW   = log2c(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [AW-1:0]                push_addr,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [AW-1:0]                head_addr,
  output logic [DW-1:0]                head_data,
  output logic [PW-1:0]                wr_ptr,
  output logic [CW-1:0]                count,
  output logic [DEPTH-1:0][AW-1:0]     ent_addr,
  output logic [DEPTH-1:0][DW-1:0]     ent_data
);

  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0][AW-1:0]  addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0]  data_q, data_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign wr_ptr    = wr_ptr_q;
  assign count     = count_q;
  assign ent_addr  = addr_q;
  assign ent_data  = data_q;

endmodule

// File: rtl/rf_wb_queue.sv
// Write-side front end of the register file: results queue in order and
// drain one per cycle onto the registered RF write port. Two lookup ports
// report the newest not-yet-committed value for a register.
//   clk, rst                       : clock, synchronous active-high reset
//   enq_valid/enq_ready/addr/data  : result handshake (addr 0 is dropped)
//   wb_stall                       : hold the head, no write this cycle
//   RegWrite/wr_addr/wr_data       : registered RF write port
//   rd_addr1/2, fwd_hit1/2, fwd_data1/2 : forwarding lookups
//   empty                          : nothing queued and no write in flight
module rf_wb_queue
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [AW-1:0] enq_addr,
  input  logic [DW-1:0] enq_data,
  input  logic          wb_stall,
  output logic          RegWrite,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          fwd_hit1,
  output logic [DW-1:0] fwd_data1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data2,
  output logic          empty
);

  localparam int unsigned PW = log2c(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic                     push, pop;
  logic [AW-1:0]            head_addr;
  logic [DW-1:0]            head_data;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            count;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;

  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [DW:0]   fwd1, fwd2;

  assign enq_ready = !rst && (count < CW'(DEPTH));
  // Writes to r0 complete the handshake but never occupy a slot.
  assign push      = enq_valid && enq_ready && (enq_addr != '0);
  assign pop       = (count != '0) && !wb_stall;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (enq_addr),
    .push_data (enq_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .wr_ptr    (wr_ptr),
    .count     (count),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  always_comb begin
    regwrite_d = pop;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (pop) begin
      wr_addr_d = head_addr;
      wr_data_d = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Scan live entries newest-first (wr_ptr-1 backwards, count of them);
  // the output stage is older than every queued entry so it is checked last.
  function automatic logic [DW:0] fwd_lookup(
    input logic [DEPTH-1:0][AW-1:0] a,
    input logic [DEPTH-1:0][DW-1:0] d,
    input logic [PW-1:0]            wp,
    input logic [CW-1:0]            cnt,
    input logic                     out_v,
    input logic [AW-1:0]            out_a,
    input logic [DW-1:0]            out_d,
    input logic [AW-1:0]            ra
  );
    logic          hit;
    logic [DW-1:0] val;
    logic [PW-1:0] idx;
    hit = 1'b0;
    val = '0;
    if (ra != '0) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = wp - PW'(i + 1);
        if (!hit && (CW'(i) < cnt) && (a[idx] == ra)) begin
          hit = 1'b1;
          val = d[idx];
        end
      end
      if (!hit && out_v && (out_a == ra)) begin
        hit = 1'b1;
        val = out_d;
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    if (!rst) begin
      fwd1 = fwd_lookup(ent_addr, ent_data, wr_ptr, count,
                        regwrite_q, wr_addr_q, wr_data_q, rd_addr1);
      fwd2 = fwd_lookup(ent_addr, ent_data, wr_ptr, count,
                        regwrite_q, wr_addr_q, wr_data_q, rd_addr2);
    end
  end

  assign {fwd_hit1, fwd_data1} = fwd1;
  assign {fwd_hit2, fwd_data2} = fwd2;

  assign RegWrite = regwrite_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign empty    = rst || ((count == '0) && !regwrite_q);

endmodule

// File: tb/tb_rf_wb_queue.sv
module tb_rf_wb_queue;
  import rf_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [4:0]  enq_addr = '0;
  logic [31:0] enq_data = '0;
  logic        wb_stall = 1'b0;
  logic        RegWrite;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        empty;

  rf_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_addr(enq_addr), .enq_data(enq_data),
    .wb_stall(wb_stall),
    .RegWrite(RegWrite), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .empty(empty)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 3 time units after the rising edge; checks happen there too.
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Reference model: pending-entry scoreboard plus expected output stage.
  wb_entry_t   mq[$];
  logic        m_rw   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  always @(posedge clk) begin
    bit acc, deq;
    wb_entry_t e;
    if (rst) begin
      mq.delete();
      m_rw = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      acc = enq_valid && (mq.size() < DEPTH);
      deq = (mq.size() > 0) && !wb_stall;
      if (deq) begin
        e = mq.pop_front();
        m_rw = 1'b1; m_addr = e.addr; m_data = e.data;
      end else begin
        m_rw = 1'b0;
      end
      if (acc && enq_addr != 5'd0) begin
        e.addr = enq_addr; e.data = enq_data;
        mq.push_back(e);
      end
    end
  end

  function automatic logic [32:0] m_fwd(input logic [4:0] ra);
    if (rst || ra == 5'd0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].addr == ra) return {1'b1, mq[i].data};
    if (m_rw && m_addr == ra) return {1'b1, m_data};
    return '0;
  endfunction

  always begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      check("mon_RegWrite", RegWrite, m_rw);
      check("mon_wr_addr", wr_addr, m_addr);
      check("mon_wr_data", wr_data, m_data);
      check("mon_enq_ready", enq_ready, !rst && (mq.size() < DEPTH));
      check("mon_empty", empty, rst || (mq.size() == 0 && !m_rw));
      check("mon_fwd1", {fwd_hit1, fwd_data1}, m_fwd(rd_addr1));
      check("mon_fwd2", {fwd_hit2, fwd_data2}, m_fwd(rd_addr2));
    end
  end

  typedef struct {
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } fwd_vec_t;

  fwd_vec_t vecs[6];

  initial begin
    // Queue contents when the table runs (oldest first): 7/11 7/22 9/33 4/44
    vecs[0] = '{5'd7,  5'd0, 1'b1, 32'h22, 1'b0, 32'h0};
    vecs[1] = '{5'd7,  5'd9, 1'b1, 32'h22, 1'b1, 32'h33};
    vecs[2] = '{5'd4,  5'd5, 1'b1, 32'h44, 1'b0, 32'h0};
    vecs[3] = '{5'd0,  5'd7, 1'b0, 32'h0,  1'b1, 32'h22};
    vecs[4] = '{5'd31, 5'd4, 1'b0, 32'h0,  1'b1, 32'h44};
    vecs[5] = '{5'd9,  5'd9, 1'b1, 32'h33, 1'b1, 32'h33};

    // Reset held for two edges
    step(); step();
    check("rst_RegWrite", RegWrite, 1'b0);
    check("rst_wr_addr", wr_addr, 5'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_enq_ready", enq_ready, 1'b0);
    check("rst_empty", empty, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_release_ready", enq_ready, 1'b1);
    mon_en = 1'b1;

    // Single-entry latency
    enq_valid = 1'b1; enq_addr = 5'd3; enq_data = 32'hAA;
    step();
    enq_valid = 1'b0;
    check("lat_N_RegWrite", RegWrite, 1'b0);
    step();
    check("lat_N1_RegWrite", RegWrite, 1'b1);
    check("lat_N1_addr", wr_addr, 5'd3);
    check("lat_N1_data", wr_data, 32'hAA);
    step();
    check("lat_N2_RegWrite", RegWrite, 1'b0);
    check("lat_hold_addr", wr_addr, 5'd3);

    // Fill under stall, hold a fifth, then drain in order
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      enq_valid = 1'b1; enq_addr = 5'(i); enq_data = 32'h100 + 32'(i);
      step();
    end
    check("full_ready", enq_ready, 1'b0);
    enq_addr = 5'd5; enq_data = 32'h105;
    step();
    check("full_hold_ready", enq_ready, 1'b0);
    check("full_hold_nowrite", RegWrite, 1'b0);
    wb_stall = 1'b0;
    step();
    check("drain_w1", {RegWrite, wr_addr, wr_data}, {1'b1, 5'd1, 32'h101});
    step();
    enq_valid = 1'b0;
    check("drain_w2", {RegWrite, wr_addr, wr_data}, {1'b1, 5'd2, 32'h102});
    for (int i = 3; i <= 5; i++) begin
      step();
      check("drain_wn", {RegWrite, wr_addr, wr_data}, {1'b1, 5'(i), 32'h100 + 32'(i)});
    end
    step();
    check("drain_idle", RegWrite, 1'b0);

    // Forwarding table against a stalled full queue
    wb_stall = 1'b1;
    enq_valid = 1'b1; enq_addr = 5'd7; enq_data = 32'h11; step();
    enq_addr = 5'd7; enq_data = 32'h22; step();
    enq_addr = 5'd9; enq_data = 32'h33; step();
    enq_addr = 5'd4; enq_data = 32'h44; step();
    enq_valid = 1'b0;
    foreach (vecs[k]) begin
      rd_addr1 = vecs[k].ra1; rd_addr2 = vecs[k].ra2;
      #1;
      check("tab_hit1", fwd_hit1, vecs[k].h1);
      check("tab_data1", fwd_data1, vecs[k].d1);
      check("tab_hit2", fwd_hit2, vecs[k].h2);
      check("tab_data2", fwd_data2, vecs[k].d2);
      step();
    end

    // Full queue: offer a new entry while the head drains in the same cycle
    enq_valid = 1'b1; enq_addr = 5'd12; enq_data = 32'hCC; wb_stall = 1'b0;
    step();
    enq_valid = 1'b0; wb_stall = 1'b1;
    check("fulldeq_ready", enq_ready, 1'b1);
    check("fulldeq_write", {RegWrite, wr_addr, wr_data}, {1'b1, 5'd7, 32'h11});
    rd_addr1 = 5'd7; rd_addr2 = 5'd12;
    #1;
    check("fulldeq_fwd7", {fwd_hit1, fwd_data1}, {1'b1, 32'h22});
    check("fulldeq_not_taken", fwd_hit2, 1'b0);
    wb_stall = 1'b0;
    step();
    wb_stall = 1'b1;
    rd_addr1 = 5'd7; rd_addr2 = 5'd9;
    #1;
    check("outstage_fwd", {fwd_hit1, fwd_data1}, {1'b1, 32'h22});
    check("queue_fwd9", {fwd_hit2, fwd_data2}, {1'b1, 32'h33});
    step();
    #1;
    check("outstage_gone", fwd_hit1, 1'b0);

    // Reset with three pending entries
    enq_valid = 1'b1; enq_addr = 5'd15; enq_data = 32'h55;
    step();
    enq_valid = 1'b0;
    rst = 1'b1; wb_stall = 1'b0; rd_addr1 = 5'd15;
    step();
    check("midrst_RegWrite", RegWrite, 1'b0);
    check("midrst_empty", empty, 1'b1);
    check("midrst_fwd", fwd_hit1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_dropped", RegWrite, 1'b0);
    end
    enq_valid = 1'b1; enq_addr = 5'd0; enq_data = 32'hDEAD;
    #1;
    check("r0_ready", enq_ready, 1'b1);
    step();
    enq_valid = 1'b0;
    check("r0_empty", empty, 1'b1);
    step();
    check("r0_nowrite", RegWrite, 1'b0);
    step();
    check("r0_nowrite2", {RegWrite, empty}, {1'b0, 1'b1});

    // Random traffic checked by the monitor
    for (int c = 0; c < 300; c++) begin
      enq_valid = ($urandom_range(0, 3) != 0);
      enq_addr  = 5'($urandom_range(0, 7));
      enq_data  = $urandom;
      wb_stall  = ($urandom_range(0, 3) == 0);
      rd_addr1  = 5'($urandom_range(0, 7));
      rd_addr2  = 5'($urandom_range(0, 7));
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    enq_valid = 1'b0; wb_stall = 1'b0; rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("final_empty", empty, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
